sha256_sched_ctrl: RTL and testbench
====================================

SHA256_SCHED_CTRL -- requirements
Module: sha256_sched_ctrl

Interface
REQ-001 SHALL have parameter EXPAND_WAIT, default 5, meaning cycles between round_t update and Wt sampling for rounds t>=16; legal range 1..15.
REQ-002 SHALL have parameter DIRECT_WAIT, default 1, meaning the same for rounds t<16; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin one 512-bit block; sampled only in IDLE.
REQ-006 SHALL have ports msg_word_in  input  32  message word; msg_valid  input  1  word present; msg_ready  output  1  controller accepts word.
REQ-007 SHALL have scheduler-side ports sched_start_new_block, sched_write_enable (output 1), sched_word_addr (output 4), sched_word_in (output 32), sched_round_t (output 6), and sched_wt (input 32, scheduler Wt_out).
REQ-008 SHALL have consumer-side ports wt_out  output  32; wt_round  output  6; wt_valid  output  1; wt_ready  input  1.
REQ-009 SHALL have status ports busy  output  1  not IDLE; done  output  1  one-cycle block-complete pulse.

Function
REQ-010 SHALL implement states IDLE, LOAD, ROUND_WAIT, ROUND_OUT, DONE.
REQ-011 IDLE: start=1 -> LOAD, load count=0; otherwise stay; msg_ready=0.
REQ-012 LOAD: msg_ready=1, sched_start_new_block=1; sched_write_enable=msg_valid, sched_word_in=msg_word_in, sched_word_addr=load count (combinational pass-through).
REQ-013 LOAD: each cycle with msg_valid&msg_ready increments load count; acceptance of word 15 -> ROUND_WAIT with round=0 and wait counter loaded; msg_valid=0 cycles stall without state change.
REQ-014 sched_round_t SHALL equal the registered round counter in ROUND_WAIT and ROUND_OUT, and 0 elsewhere.
REQ-015 ROUND_WAIT: wait counter counts DIRECT_WAIT (round<16) or EXPAND_WAIT (round>=16) cycles; on expiry capture sched_wt into wt_out, round into wt_round, -> ROUND_OUT.
REQ-016 ROUND_OUT: wt_valid=1, wt_out/wt_round stable until wt_valid&wt_ready; on handshake round<63 -> round+1, ROUND_WAIT; round=63 -> DONE.
REQ-017 DONE: done=1 for exactly one cycle, -> IDLE next cycle.
REQ-018 wt_ready while wt_valid=0 SHALL have no effect; start outside IDLE SHALL be ignored; msg_valid outside LOAD SHALL not write the scheduler.
REQ-019 Round counter SHALL never exceed 63; no wrap to 0 inside a block.
REQ-020 With wt_ready held 1, latency start->done SHALL be 1+16+16*(DIRECT_WAIT+1)+48*(EXPAND_WAIT+1)+1 cycles given msg_valid always 1 (defaults: 338).

Reset
REQ-021 reset_n=0 at a clock edge SHALL force IDLE, counters 0, wt_out=0, wt_round=0, wt_valid=0, done=0, busy=0, msg_ready=0, all sched_* outputs 0, regardless of state.
REQ-022 Reset mid-block SHALL discard the block; next start restarts load from address 0.

Configuration
REQ-023 Macro SHA256_SCHED_CTRL_ABORT_EN defined: input abort (1 bit) exists; abort=1 in any non-IDLE state -> IDLE next cycle with REQ-021 values except no done pulse; abort has priority over all transitions but not over reset_n.
REQ-024 Macro undefined: abort port absent; block always runs to DONE.

Verification
REQ-025 Reset, start, load M[i]=i+0x10 with msg_valid=1 -> sched_word_addr 0..15 on consecutive cycles, sched_write_enable=1 for 16 cycles, then ROUND_WAIT round 0.
REQ-026 Behavioral scheduler model, wt_ready=1 -> wt_out for rounds 0..15 equals 0x10..0x1F, 64 wt_valid handshakes, done pulse 338 cycles after start.
REQ-027 Round 16 -> wt_valid rises exactly EXPAND_WAIT+1=6 cycles after sched_round_t becomes 16.
REQ-028 wt_ready=0 for 10 cycles at round 20 -> wt_out, wt_round=20, sched_round_t held; release -> round 21.
REQ-029 msg_valid dropped for 3 cycles after word 7 -> no writes, address stays 8, load resumes; start pulsed during rounds -> ignored.
REQ-030 reset_n=0 at round 40 -> all outputs 0 next cycle; with SHA256_SCHED_CTRL_ABORT_EN, abort at round 40 -> IDLE, done never asserts.

Source files
------------

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller for a SHA-256 message scheduler. It loads the sixteen
// 32-bit words of one 512-bit block into the scheduler, then steps through
// rounds 0..63. For each round it waits a fixed number of cycles for the
// scheduler's Wt to settle, captures it and offers it to a consumer through a
// valid/ready handshake.
//
// Parameters
//   EXPAND_WAIT  settle cycles between round update and Wt capture, t >= 16 (1..15)
//   DIRECT_WAIT  settle cycles between round update and Wt capture, t <  16 (1..15)
//
// Ports
//   clk                    sole clock, rising edge
//   reset_n                synchronous active-low reset
//   abort                  (only with SHA256_SCHED_CTRL_ABORT_EN) drop the current block
//   start                  begin one block; only looked at while idle
//   msg_word_in/msg_valid  message word source; msg_ready high while loading
//   sched_start_new_block  high for the whole load phase
//   sched_write_enable     scheduler write strobe (msg_valid during load)
//   sched_word_addr        word index being written (0..15)
//   sched_word_in          message word pass-through to the scheduler
//   sched_round_t          round index presented to the scheduler
//   sched_wt               Wt returned by the scheduler
//   wt_out/wt_round        captured Wt and its round number
//   wt_valid/wt_ready      consumer handshake
//   busy                   controller not idle
//   done                   one-cycle pulse after round 63 is handed off
//
// Build option
//   SHA256_SCHED_CTRL_ABORT_EN  adds the abort input; without it every started
//                               block runs through to done.
// -----------------------------------------------------------------------------
module sha256_sched_ctrl #(
  parameter int unsigned EXPAND_WAIT = 5,
  parameter int unsigned DIRECT_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef SHA256_SCHED_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [31:0] msg_word_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        sched_start_new_block,
  output logic        sched_write_enable,
  output logic [3:0]  sched_word_addr,
  output logic [31:0] sched_word_in,
  output logic [5:0]  sched_round_t,
  input  logic [31:0] sched_wt,
  output logic [31:0] wt_out,
  output logic [5:0]  wt_round,
  output logic        wt_valid,
  input  logic        wt_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND_WAIT,
    S_ROUND_OUT,
    S_DONE
  } state_t;

  // The wait counter is loaded with N-1 and the capture happens on the cycle
  // it reads zero, so ROUND_WAIT lasts exactly N cycles.
  localparam logic [3:0] DIRECT_RELOAD = 4'(DIRECT_WAIT - 1);
  localparam logic [3:0] EXPAND_RELOAD = 4'(EXPAND_WAIT - 1);

  state_t      state_reg,    state_next;
  logic [3:0]  load_cnt_reg, load_cnt_next;
  logic [5:0]  round_reg,    round_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] wt_out_reg,   wt_out_next;
  logic [5:0]  wt_round_reg, wt_round_next;
  logic        abort_hit;

`ifdef SHA256_SCHED_CTRL_ABORT_EN
  assign abort_hit = abort && (state_reg != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      load_cnt_reg <= 4'd0;
      round_reg    <= 6'd0;
      wait_cnt_reg <= 4'd0;
      wt_out_reg   <= 32'd0;
      wt_round_reg <= 6'd0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      round_reg    <= round_next;
      wait_cnt_reg <= wait_cnt_next;
      wt_out_reg   <= wt_out_next;
      wt_round_reg <= wt_round_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    load_cnt_next         = load_cnt_reg;
    round_next            = round_reg;
    wait_cnt_next         = wait_cnt_reg;
    wt_out_next           = wt_out_reg;
    wt_round_next         = wt_round_reg;
    msg_ready             = 1'b0;
    sched_start_new_block = 1'b0;
    sched_write_enable    = 1'b0;
    sched_word_addr       = 4'd0;
    sched_word_in         = 32'd0;
    sched_round_t         = 6'd0;
    wt_valid              = 1'b0;
    busy                  = (state_reg != S_IDLE);
    done                  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LOAD;
          load_cnt_next = 4'd0;
        end
      end

      S_LOAD: begin
        msg_ready             = 1'b1;
        sched_start_new_block = 1'b1;
        sched_write_enable    = msg_valid;
        sched_word_addr       = load_cnt_reg;
        sched_word_in         = msg_word_in;
        if (msg_valid) begin
          if (load_cnt_reg == 4'd15) begin
            state_next    = S_ROUND_WAIT;
            load_cnt_next = 4'd0;
            round_next    = 6'd0;
            wait_cnt_next = DIRECT_RELOAD;
          end else begin
            load_cnt_next = load_cnt_reg + 4'd1;
          end
        end
      end

      S_ROUND_WAIT: begin
        sched_round_t = round_reg;
        if (wait_cnt_reg == 4'd0) begin
          state_next    = S_ROUND_OUT;
          wt_out_next   = sched_wt;
          wt_round_next = round_reg;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end

      S_ROUND_OUT: begin
        sched_round_t = round_reg;
        wt_valid      = 1'b1;
        if (wt_ready) begin
          if (round_reg == 6'd63) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ROUND_WAIT;
            round_next = round_reg + 6'd1;
            // The round being entered is round_reg+1, so the expansion wait
            // starts when leaving round 15.
            wait_cnt_next = (round_reg >= 6'd15) ? EXPAND_RELOAD : DIRECT_RELOAD;
          end
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
        round_next = 6'd0;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort returns everything to the reset picture without a done pulse.
    if (abort_hit) begin
      state_next    = S_IDLE;
      load_cnt_next = 4'd0;
      round_next    = 6'd0;
      wait_cnt_next = 4'd0;
      wt_out_next   = 32'd0;
      wt_round_next = 6'd0;
    end
  end

  assign wt_out   = wt_out_reg;
  assign wt_round = wt_round_reg;

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl
// Directed bench for sha256_sched_ctrl with a behavioural SHA-256 message
// scheduler hooked to the scheduler-side ports. Expected (round, Wt) pairs are
// queued when a block is loaded and popped on every consumer handshake.
module tb_sha256_sched_ctrl;

  localparam int EXPAND_WAIT = 5;
  localparam int DIRECT_WAIT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] msg_word_in;
  logic        msg_valid;
  logic        msg_ready;
  logic        sched_start_new_block;
  logic        sched_write_enable;
  logic [3:0]  sched_word_addr;
  logic [31:0] sched_word_in;
  logic [5:0]  sched_round_t;
  logic [31:0] sched_wt;
  logic [31:0] wt_out;
  logic [5:0]  wt_round;
  logic        wt_valid;
  logic        wt_ready;
  logic        busy;
  logic        done;
`ifdef SHA256_SCHED_CTRL_ABORT_EN
  logic        abort;
`endif

  int          checks   = 0;
  int          errors   = 0;
  int          hs_count = 0;
  logic [37:0] sb [$];
  logic [37:0] mon_e;
  logic [511:0] msg_blk;
  logic [511:0] model_mem;
  logic        hs_ok;

  always #5 clk = ~clk;

  sha256_sched_ctrl #(
    .EXPAND_WAIT(EXPAND_WAIT),
    .DIRECT_WAIT(DIRECT_WAIT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
`ifdef SHA256_SCHED_CTRL_ABORT_EN
    .abort                (abort),
`endif
    .start                (start),
    .msg_word_in          (msg_word_in),
    .msg_valid            (msg_valid),
    .msg_ready            (msg_ready),
    .sched_start_new_block(sched_start_new_block),
    .sched_write_enable   (sched_write_enable),
    .sched_word_addr      (sched_word_addr),
    .sched_word_in        (sched_word_in),
    .sched_round_t        (sched_round_t),
    .sched_wt             (sched_wt),
    .wt_out               (wt_out),
    .wt_round             (wt_round),
    .wt_valid             (wt_valid),
    .wt_ready             (wt_ready),
    .busy                 (busy),
    .done                 (done)
  );

  // ---------------- SHA-256 message expansion ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] sha_w(input logic [511:0] blk, input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
    for (int i = 16; i <= t; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    return w[t];
  endfunction

  // Behavioural scheduler: stores written words, returns Wt for the presented round.
  always @(posedge clk) begin
    if (sched_write_enable) model_mem[int'(sched_word_addr)*32 +: 32] <= sched_word_in;
  end
  assign sched_wt = sha_w(model_mem, int'(sched_round_t));

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push_expected();
    sb.delete();
    for (int t = 0; t < 64; t++) sb.push_back({6'(t), sha_w(msg_blk, t)});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_msg_ready"}, msg_ready, 0);
    chk({tag, "_wt_valid"},  wt_valid, 0);
    chk({tag, "_wt_out"},    wt_out, 0);
    chk({tag, "_wt_round"},  wt_round, 0);
    chk({tag, "_round_t"},   sched_round_t, 0);
    chk({tag, "_we"},        sched_write_enable, 0);
    chk({tag, "_newblk"},    sched_start_new_block, 0);
    chk({tag, "_addr"},      sched_word_addr, 0);
    chk({tag, "_word"},      sched_word_in, 0);
  endtask

  // Start pulse, sixteen load cycles (optional 3-cycle msg_valid gap after
  // word gap_after), then the first ROUND_WAIT cycle.
  task automatic load_msg(input int gap_after);
    next_cycle(); start = 1'b1; msg_valid = 1'b1; msg_word_in = 32'h0;
    settle();
    chk("idle_msg_ready", msg_ready, 0);
    chk("idle_we", sched_write_enable, 0);
    for (int i = 0; i < 16; i++) begin
      next_cycle(); start = 1'b0; msg_valid = 1'b1; msg_word_in = msg_blk[i*32 +: 32];
      settle();
      chk("load_addr", sched_word_addr, i);
      chk("load_we", sched_write_enable, 1);
      chk("load_word", sched_word_in, msg_blk[i*32 +: 32]);
      chk("load_newblk", sched_start_new_block, 1);
      chk("load_ready", msg_ready, 1);
      $display("load addr %0d word %08h", sched_word_addr, sched_word_in);
      if (i == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          next_cycle(); msg_valid = 1'b0; msg_word_in = 32'hDEADBEEF;
          settle();
          chk("gap_we", sched_write_enable, 0);
          chk("gap_addr", sched_word_addr, i + 1);
          chk("gap_ready", msg_ready, 1);
        end
      end
    end
    next_cycle(); msg_valid = 1'b0; msg_word_in = 32'h0;
    settle();
    chk("rw0_round", sched_round_t, 0);
    chk("rw0_busy", busy, 1);
    chk("rw0_ready", msg_ready, 0);
    chk("rw0_valid", wt_valid, 0);
    chk("rw0_newblk", sched_start_new_block, 0);
  endtask

  task automatic wait_round(input logic [5:0] target, input int budget);
    int got;
    got = 0;
    for (int n = 0; n < budget && got == 0; n++) begin
      next_cycle();
      settle();
      if (sched_round_t == target && busy) got = 1;
    end
    chk("wait_round_timeout", got, 1);
  endtask

  task automatic run_until_done(input int budget);
    int got;
    got = 0;
    for (int n = 0; n < budget && got == 0; n++) begin
      next_cycle();
      settle();
      if (done) got = 1;
    end
    chk("done_timeout", got, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
`ifdef SHA256_SCHED_CTRL_ABORT_EN
  assign hs_ok = reset_n && wt_valid && wt_ready && !abort;
`else
  assign hs_ok = reset_n && wt_valid && wt_ready;
`endif

  always @(negedge clk) begin
    if (hs_ok) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("hs_round", wt_round, mon_e[37:32]);
        chk("hs_wt", wt_out, mon_e[31:0]);
      end
      hs_count++;
      $display("handshake round %0d wt %08h", wt_round, wt_out);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int got;
    int r16_seen;
    int r16_valid;
    logic [31:0] exp20;
`ifdef SHA256_SCHED_CTRL_ABORT_EN
    int seen_done;
    abort = 1'b0;
`endif
    reset_n = 1'b0; start = 1'b0; msg_word_in = 32'h0; msg_valid = 1'b0; wt_ready = 1'b0;
    model_mem = '0;
    repeat (3) next_cycle();
    reset_n = 1'b1;
    settle();
    check_all_zero("reset");

    // Block 1: M[i] = i + 0x10, wt_ready held high, latency and round 16 timing.
    for (int i = 0; i < 16; i++) msg_blk[i*32 +: 32] = 32'h10 + i;
    push_expected();
    hs_count = 0;
    wt_ready = 1'b1;
    load_msg(-1);
    cyc = 18;  // start cycle + 16 load cycles + first ROUND_WAIT cycle
    got = 0; r16_seen = 0; r16_valid = 0;
    while (got == 0 && cyc < 1000) begin
      next_cycle(); cyc++;
      start = (cyc == 100);  // stray start while rounds are running
      settle();
      if (sched_round_t == 16 && r16_seen == 0) r16_seen = cyc;
      if (wt_valid && wt_round == 16 && r16_valid == 0) r16_valid = cyc;
      if (done) got = 1;
    end
    start = 1'b0;
    chk("b1_done_seen", got, 1);
    chk("b1_latency", cyc, 338);
    chk("b1_r16_cycles", r16_valid - r16_seen + 1, EXPAND_WAIT + 1);
    next_cycle(); settle();
    chk("b1_done_pulse", done, 0);
    chk("b1_idle_busy", busy, 0);
    chk("b1_handshakes", hs_count, 64);
    chk("b1_sb_left", sb.size(), 0);

    // Block 2: random message, msg_valid gap after word 7, consumer stall at round 20.
    for (int i = 0; i < 16; i++) msg_blk[i*32 +: 32] = $urandom();
    push_expected();
    exp20 = sha_w(msg_blk, 20);
    hs_count = 0;
    load_msg(7);
    wait_round(6'd20, 500);
    next_cycle(); wt_ready = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      settle();
      if (wt_valid) got = 1;
      else next_cycle();
    end
    chk("stall_valid_seen", got, 1);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) begin
        next_cycle(); settle();
      end
      chk("stall_valid", wt_valid, 1);
      chk("stall_wt_round", wt_round, 20);
      chk("stall_wt_out", wt_out, exp20);
      chk("stall_round_t", sched_round_t, 20);
    end
    next_cycle(); wt_ready = 1'b1;
    settle();
    next_cycle(); settle();
    chk("release_round_t", sched_round_t, 21);
    chk("release_valid", wt_valid, 0);
    run_until_done(600);
    next_cycle(); settle();
    chk("b2_handshakes", hs_count, 64);
    chk("b2_sb_left", sb.size(), 0);

    // Block 3: reset in the middle of round 40.
    for (int i = 0; i < 16; i++) msg_blk[i*32 +: 32] = $urandom();
    push_expected();
    hs_count = 0;
    load_msg(-1);
    wait_round(6'd40, 500);
    next_cycle(); reset_n = 1'b0;
    next_cycle(); reset_n = 1'b1;
    settle();
    check_all_zero("midrst");
    chk("b3_handshakes", hs_count, 40);
    sb.delete();

`ifdef SHA256_SCHED_CTRL_ABORT_EN
    // Block 4: fresh load restarts at address 0, then abort at round 40.
    for (int i = 0; i < 16; i++) msg_blk[i*32 +: 32] = $urandom();
    push_expected();
    hs_count = 0;
    load_msg(-1);
    wait_round(6'd40, 500);
    next_cycle(); abort = 1'b1;
    next_cycle(); abort = 1'b0;
    settle();
    check_all_zero("abort");
    seen_done = 0;
    for (int n = 0; n < 20; n++) begin
      next_cycle(); settle();
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    chk("b4_handshakes", hs_count, 40);
    sb.delete();
`else
    // Block 4: after the mid-block reset a new start loads from address 0.
    next_cycle(); start = 1'b1; msg_valid = 1'b1; msg_word_in = 32'hA5A50000;
    next_cycle(); start = 1'b0;
    settle();
    chk("restart_addr", sched_word_addr, 0);
    chk("restart_we", sched_write_enable, 1);
    next_cycle(); reset_n = 1'b0; msg_valid = 1'b0;
    next_cycle(); reset_n = 1'b1;
    settle();
    check_all_zero("final");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
